// File: rtl/fee_edata_pkg.sv
// fee_edata_pkg: frame markers, FSM state codes and trailer field offsets shared with the DTC-side decoder
package fee_edata_pkg;
  localparam logic [7:0] FEE_HDR_MARK = 8'hA5;
  localparam logic [7:0] FEE_TRL_MARK = 8'h5A;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_TRL_WC  = 3'd3;
  localparam logic [2:0] ST_TRL_CS  = 3'd4;
  localparam int TRL_WC_LSB    = 0;
  localparam int TRL_TMO_BIT   = 18;
  localparam int TRL_ABORT_BIT = 19;
  localparam int TRL_MARK_LSB  = 24;
endpackage

// File: rtl/edata_skid2.sv
// edata_skid2: 2-entry 32-bit skid FIFO with occupancy and a flush that also discards a same-cycle push
module edata_skid2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] dout,
  output logic [1:0]  occ
);
  logic [31:0] mem_q [2];
  logic        wp_q, wp_d, rp_q, rp_d, do_pop;
  logic [1:0]  occ_q, occ_d;
  // pointer and occupancy update; popping an empty buffer is ignored
  always_comb begin
    do_pop = pop & (occ_q != 2'd0);
    wp_d   = flush ? 1'b0 : wp_q ^ push;
    rp_d   = flush ? 1'b0 : rp_q ^ do_pop;
    occ_d  = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, do_pop};
  end
  // state registers; storage is not reset because occupancy qualifies it
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
    if (push & !flush) mem_q[wp_q] <= din;
  end
  assign dout = mem_q[rp_q];
  assign occ  = occ_q;
endmodule

// File: rtl/fee_edata_framer.sv
// fee_edata_framer: drains one ALTRO event from the readout FIFO and frames it (header, payload, wc, checksum) for the DTC link
module fee_edata_framer
  import fee_edata_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 65535,
  parameter logic [7:0] HDR_MARK    = FEE_HDR_MARK,
  parameter logic [7:0] TRL_MARK    = FEE_TRL_MARK
) (
  input  logic        rdoclk,
  input  logic        reset,
  input  logic        evt_start,
  input  logic        evt_end,
  input  logic        evt_abort,
  input  logic [4:0]  fee_addr,
  output logic        fifo_rdreq,
  input  logic [31:0] fifo_q,
  input  logic        fifo_empty,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic [15:0] evt_cnt,
  output logic [2:0]  err_flags
);
  logic [2:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wc_q, wc_d, to_cnt_q, to_cnt_d, evt_cnt_q, evt_cnt_d;
  logic [31:0] cs_q, cs_d;
  logic        end_q, end_d, abort_q, abort_d, to_q, to_d;
  logic        commit_q, commit_d, inflight_q;
  logic [2:0]  err_q, err_d;
  logic        idle, is_hdr, is_pl, is_wc, is_cs, acc, pop, flush, run, tmo_hit, pl_done;
  logic [2:0]  credit;
  logic [31:0] skid_dout;
  logic [1:0]  skid_occ;
  edata_skid2 u_skid (
    .clk   (rdoclk),
    .rst   (reset),
    .push  (inflight_q),
    .din   (fifo_q),
    .pop   (pop),
    .flush (flush),
    .dout  (skid_dout),
    .occ   (skid_occ)
  );
  // link output mux and read-path control; after an abort only an already-presented beat may complete
  always_comb begin
    idle       = state_q == ST_IDLE;
    is_hdr     = state_q == ST_HDR;
    is_pl      = state_q == ST_PAYLOAD;
    is_wc      = state_q == ST_TRL_WC;
    is_cs      = state_q == ST_TRL_CS;
    tx_valid   = is_hdr | is_wc | is_cs | (is_pl & (skid_occ != 2'd0) & (!abort_q | commit_q));
    tx_data    = is_hdr ? {HDR_MARK, 3'b000, addr_q, evt_cnt_q} :
                 is_wc  ? {TRL_MARK, 4'h0, abort_q, to_q, 2'b00, wc_q} :
                 is_cs  ? cs_q :
                 (is_pl & tx_valid) ? skid_dout : 32'h0;
    tx_sof     = is_hdr;
    tx_eof     = is_cs;
    busy       = !idle | evt_start;
    acc        = tx_valid & tx_ready;
    pop        = is_pl & acc;
    flush      = is_pl & abort_q & !commit_q;
    credit     = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rdreq = is_pl & !fifo_empty & !abort_q & !to_q & (credit < 3'd2);
    run        = is_pl & fifo_empty & !end_q & (skid_occ == 2'd0) & !to_q & !abort_q;
    tmo_hit    = run & ((to_cnt_q + 16'd1) == 16'(TIMEOUT_CYC));
    pl_done    = is_pl & ((end_q & fifo_empty) | abort_q | to_q) & !inflight_q & (skid_occ == 2'd0);
  end
  // FSM, event latches, word count, checksum, timeout and status counters
  always_comb begin
    state_d   = idle   ? (evt_start ? ST_HDR : ST_IDLE) :
                is_hdr ? (acc ? ST_PAYLOAD : ST_HDR) :
                is_pl  ? (pl_done ? ST_TRL_WC : ST_PAYLOAD) :
                is_wc  ? (acc ? ST_TRL_CS : ST_TRL_WC) :
                is_cs  ? (acc ? ST_IDLE : ST_TRL_CS) : ST_IDLE;
    addr_d    = (idle & evt_start) ? fee_addr : addr_q;
    end_d     = idle ? (evt_start & evt_end) : (end_q | evt_end);
    abort_d   = idle ? 1'b0 : (abort_q | (evt_abort & (is_hdr | is_pl)));
    to_d      = idle ? 1'b0 : (to_q | tmo_hit);
    to_cnt_d  = (idle | fifo_rdreq) ? 16'd0 : run ? to_cnt_q + 16'd1 : to_cnt_q;
    wc_d      = idle ? 16'd0 : (pop & (wc_q != 16'hFFFF)) ? wc_q + 16'd1 : wc_q;
    cs_d      = idle ? 32'h0 : pop ? cs_q ^ skid_dout : cs_q;
    commit_d  = is_pl & tx_valid & !tx_ready;
    err_d     = err_q | {evt_abort & !idle, tmo_hit, evt_start & !idle};
    evt_cnt_d = evt_cnt_q + {15'd0, is_cs & acc};
  end
  // state registers; reset drops any in-flight read and truncates the frame
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 5'd0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      to_q       <= 1'b0;
      to_cnt_q   <= 16'd0;
      wc_q       <= 16'd0;
      cs_q       <= 32'h0;
      commit_q   <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 3'd0;
      evt_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      abort_q    <= abort_d;
      to_q       <= to_d;
      to_cnt_q   <= to_cnt_d;
      wc_q       <= wc_d;
      cs_q       <= cs_d;
      commit_q   <= commit_d;
      inflight_q <= fifo_rdreq;
      err_q      <= err_d;
      evt_cnt_q  <= evt_cnt_d;
    end
  end
  assign evt_cnt   = evt_cnt_q;
  assign err_flags = err_q;
endmodule

// File: tb/tb_fee_edata_framer.sv
// tb_fee_edata_framer: directed checks of the event framer against a FIFO model and hand-computed frames
module tb_fee_edata_framer;
  logic        rdoclk = 0, reset = 1, evt_start = 0, evt_end = 0, evt_abort = 0;
  logic [4:0]  fee_addr = 5'h13;
  logic        fifo_rdreq, fifo_empty, tx_valid, tx_ready, tx_sof, tx_eof, busy;
  logic [31:0] fifo_q = 0, tx_data;
  logic [15:0] evt_cnt;
  logic [2:0]  err_flags;
  int n_tests = 0, n_fail = 0;
  always #5 rdoclk = ~rdoclk;
  fee_edata_framer #(.TIMEOUT_CYC(16)) dut (
    .rdoclk(rdoclk), .reset(reset), .evt_start(evt_start), .evt_end(evt_end), .evt_abort(evt_abort),
    .fee_addr(fee_addr), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .busy(busy), .evt_cnt(evt_cnt), .err_flags(err_flags)
  );
  logic [31:0] fmem [256];
  logic [7:0]  wr_ptr = 0, rd_ptr = 0;
  logic        fifo_clr = 0;
  assign fifo_empty = wr_ptr == rd_ptr;
  always @(posedge rdoclk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rdreq && !fifo_empty) begin
      fifo_q <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end
  logic rdy_base = 1, tog_en = 0, tog = 0;
  assign tx_ready = tog_en ? tog : rdy_base;
  always @(posedge rdoclk) tog <= ~tog;
  int cyc = 0, stab_err = 0, rde_err = 0, n_eof = 0;
  logic [31:0] bq [$];
  int          bcyc [$];
  logic [1:0]  bfl [$];
  logic        pv = 0, pr = 0, ps = 0, pe = 0;
  logic [31:0] pd = 0;
  always @(negedge rdoclk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (fifo_rdreq && fifo_empty) rde_err <= rde_err + 1;
      if (pv && !pr && (!tx_valid || tx_data != pd || tx_sof != ps || tx_eof != pe)) stab_err <= stab_err + 1;
      if (tx_valid && tx_ready) begin
        bq.push_back(tx_data);
        bcyc.push_back(cyc);
        bfl.push_back({tx_sof, tx_eof});
        if (tx_eof) n_eof <= n_eof + 1;
      end
    end
    pv <= tx_valid & !reset;
    pr <= tx_ready;
    pd <= tx_data;
    ps <= tx_sof;
    pe <= tx_eof;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge rdoclk);
    #1;
  endtask
  function automatic logic [31:0] beat(input int i);
    return (i < bq.size()) ? bq[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [1:0] flg(input int i);
    return (i < bfl.size()) ? bfl[i] : 2'b11;
  endfunction
  task automatic load(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask
  task automatic wait_empty(input string tag);
    int k = 0;
    while (!fifo_empty && k < 500) begin tick(); k++; end
    chk({tag, "_drained"}, 32'(fifo_empty), 1);
  endtask
  task automatic wait_eof(input int ne, input string tag);
    int k = 0;
    while (n_eof == ne && k < 3000) begin tick(); k++; end
    chk({tag, "_eof_seen"}, 32'(n_eof > ne), 1);
  endtask
  task automatic pulse_end();
    evt_end = 1; tick(); evt_end = 0;
  endtask
  logic [31:0] e1 [6] = '{32'hA5130000, 32'h1, 32'h2, 32'h4, 32'h5A000003, 32'h7};
  initial begin
    int b0, ne, bad, n;
    logic [31:0] cs;
    tick(3);
    reset = 0;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_evt_cnt", 32'(evt_cnt), 0);
    chk("rst_err", 32'(err_flags), 0);
    chk("rst_rdreq", 32'(fifo_rdreq), 0);
    chk("rst_data", tx_data, 0);
    evt_abort = 1; tick(); evt_abort = 0; tick();
    chk("idle_abort_ignored", 32'(err_flags), 0);
    // 1: three words
    b0 = bq.size(); ne = n_eof;
    load(32'h1); load(32'h2); load(32'h4);
    evt_start = 1; #1;
    chk("t1_busy_same_cycle", 32'(busy), 1);
    @(posedge rdoclk); #1 evt_start = 0;
    wait_empty("t1"); pulse_end(); wait_eof(ne, "t1");
    chk("t1_beats", bq.size() - b0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_beat%0d", i), beat(b0 + i), e1[i]);
    chk("t1_sof_beat0", 32'(flg(b0)), 2'b10);
    chk("t1_eof_beat5", 32'(flg(b0 + 5)), 2'b01);
    chk("t1_evt_cnt", 32'(evt_cnt), 1);
    chk("t1_busy_after", 32'(busy), 0);
    // 2: 64 preloaded words at full rate
    b0 = bq.size(); ne = n_eof; cs = 0;
    for (int i = 0; i < 64; i++) begin load(32'hC0DE0000 + i); cs ^= 32'hC0DE0000 + i; end
    evt_start = 1; tick(); evt_start = 0;
    wait_empty("t2"); pulse_end(); wait_eof(ne, "t2");
    chk("t2_beats", bq.size() - b0, 67);
    chk("t2_hdr", beat(b0), 32'hA5130001);
    bad = 0;
    for (int i = 0; i < 64; i++) if (beat(b0 + 1 + i) !== 32'hC0DE0000 + i) bad++;
    chk("t2_payload", bad, 0);
    chk("t2_consec", (b0 + 64 < bcyc.size()) ? bcyc[b0 + 64] - bcyc[b0 + 1] : -1, 63);
    chk("t2_trl_wc", beat(b0 + 65), 32'h5A000040);
    chk("t2_trl_cs", beat(b0 + 66), cs);
    // 3: ready toggling every cycle
    b0 = bq.size(); ne = n_eof; cs = 0;
    for (int i = 0; i < 10; i++) begin load(32'h3000 + i * 7); cs ^= 32'h3000 + i * 7; end
    tog_en = 1;
    evt_start = 1; tick(); evt_start = 0;
    wait_empty("t3"); pulse_end(); wait_eof(ne, "t3");
    tog_en = 0;
    chk("t3_beats", bq.size() - b0, 13);
    chk("t3_hdr", beat(b0), 32'hA5130002);
    bad = 0;
    for (int i = 0; i < 10; i++) if (beat(b0 + 1 + i) !== 32'h3000 + i * 7) bad++;
    chk("t3_payload", bad, 0);
    chk("t3_trl_wc", beat(b0 + 11), 32'h5A00000A);
    chk("t3_trl_cs", beat(b0 + 12), cs);
    // 4: abort after four payload beats
    b0 = bq.size(); ne = n_eof;
    for (int i = 0; i < 20; i++) load(32'h400 + i);
    evt_start = 1; tick(); evt_start = 0;
    begin
      int k = 0;
      while (bq.size() - b0 < 5 && k < 200) begin tick(); k++; end
    end
    evt_abort = 1; tick(); evt_abort = 0;
    wait_eof(ne, "t4");
    fifo_clr = 1; tick(); fifo_clr = 0;
    n = bq.size() - b0 - 3;
    chk("t4_n_range", 32'(n >= 4 && n < 20), 1);
    chk("t4_hdr", beat(b0), 32'hA5130003);
    bad = 0; cs = 0;
    for (int i = 0; i < n; i++) begin
      if (beat(b0 + 1 + i) !== 32'h400 + i) bad++;
      cs ^= 32'h400 + i;
    end
    chk("t4_payload", bad, 0);
    chk("t4_trl_wc", beat(b0 + n + 1), {8'h5A, 4'h0, 1'b1, 1'b0, 2'b00, 16'(n)});
    chk("t4_trl_cs", beat(b0 + n + 2), cs);
    chk("t4_err", 32'(err_flags), 3'b100);
    chk("t4_busy_after", 32'(busy), 0);
    // 5: no data, no end -> timeout
    b0 = bq.size(); ne = n_eof;
    evt_start = 1; tick(); evt_start = 0;
    wait_eof(ne, "t5");
    chk("t5_beats", bq.size() - b0, 3);
    chk("t5_hdr", beat(b0), 32'hA5130004);
    chk("t5_trl_wc", beat(b0 + 1), 32'h5A040000);
    chk("t5_trl_cs", beat(b0 + 2), 32'h0);
    chk("t5_err", 32'(err_flags), 3'b110);
    chk("t5_evt_cnt", 32'(evt_cnt), 5);
    // 6: start while busy, then reset mid-payload
    evt_start = 1; tick(); evt_start = 0;
    tick(3);
    evt_start = 1; tick(); evt_start = 0;
    chk("t6_err_start_busy", 32'(err_flags), 3'b111);
    chk("t6_busy_mid", 32'(busy), 1);
    reset = 1; tick(2); reset = 0;
    chk("t6_rst_valid", 32'(tx_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_evt_cnt", 32'(evt_cnt), 0);
    chk("t6_rst_err", 32'(err_flags), 0);
    chk("t6_rst_sofeof", {30'd0, tx_sof, tx_eof}, 0);
    b0 = bq.size(); ne = n_eof;
    evt_start = 1; evt_end = 1; tick(); evt_start = 0; evt_end = 0;
    wait_eof(ne, "t6");
    chk("t6_beats", bq.size() - b0, 3);
    chk("t6_hdr", beat(b0), 32'hA5130000);
    chk("t6_trl_wc", beat(b0 + 1), 32'h5A000000);
    chk("t6_trl_cs", beat(b0 + 2), 32'h0);
    chk("t6_evt_cnt", 32'(evt_cnt), 1);
    chk("stream_stable", stab_err, 0);
    chk("no_read_when_empty", rde_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
